// File: rtl/circuito_seq_if.sv
// Start/status and datapath bundle between the circuito_seq sweep controller
// and its environment.
interface circuito_seq_if #(
  parameter int unsigned ERRW = 5
);
  logic            start;
  logic            cfg_b0;
  logic            cfg_b2;
  logic            x0;
  logic            x1;
  logic            b0;
  logic [4:0]      b1;
  logic            b2;
  logic            e;
  logic            busy;
  logic            done;
  logic [ERRW-1:0] err_cnt;

  // Environment side: issues start/config and returns the datapath response
  modport master (
    output start, cfg_b0, cfg_b2, x0, x1,
    input  b0, b1, b2, e, busy, done, err_cnt
  );

  // Controller side
  modport slave (
    input  start, cfg_b0, cfg_b2, x0, x1,
    output b0, b1, b2, e, busy, done, err_cnt
  );
endinterface

// File: rtl/circuito_seq.sv
// Self-checking b1 sweep controller for the circuito datapath.
// Optional build macro CIRCUITO_SEQ_B0_TOGGLE_EN: invert b0 on every step advance.
module circuito_seq #(
  parameter int unsigned LAST = 30,
  parameter int unsigned ERRW = 5
) (
  input  logic           clk,
  input  logic           rst,
  circuito_seq_if.slave  bus
);

  localparam int unsigned    IW       = 5;
  localparam logic [IW-1:0]  LAST_IDX = IW'(LAST);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            b0_q, b0_d;
  logic [IW-1:0]   b1_q, b1_d;
  logic            b2_q, b2_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            e_q, e_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mismatch_c;

  // Expected response of a healthy datapath: x1 follows b0, x0 is its complement
  assign mismatch_c = (bus.x1 != b0_q) || (bus.x0 != ~b0_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b0_q    <= 1'b0;
      b1_q    <= '0;
      b2_q    <= 1'b0;
      err_q   <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      err_q   <= err_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; status flags are decoded from the next state so they register in step
  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    err_d   = err_q;
    e_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          b1_d    = '0;
          b0_d    = bus.cfg_b0;
          b2_d    = bus.cfg_b2;
          err_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch_c && (err_q != ERR_MAX)) begin
          err_d = err_q + ERRW'(1);
        end
        if (b1_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          b1_d    = b1_q + IW'(1);
`ifdef CIRCUITO_SEQ_B0_TOGGLE_EN
          b0_d    = ~b0_q;
`endif
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    e_d    = (state_d == DRIVE) || (state_d == SAMPLE);
    busy_d = e_d;
    done_d = (state_d == DONE);
  end

  assign bus.b0      = b0_q;
  assign bus.b1      = b1_q;
  assign bus.b2      = b2_q;
  assign bus.e       = e_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_circuito_seq.sv
// Directed bench for circuito_seq: three instances (LAST=30, LAST=3/ERRW=2, LAST=0)
// driven against a behavioural datapath that can be switched to a faulty variant.
module tb_circuito_seq;

`ifdef CIRCUITO_SEQ_B0_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault_a = 1'b0;
  logic fault_b = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  circuito_seq_if #(.ERRW(5)) ifa ();
  circuito_seq_if #(.ERRW(2)) ifb ();
  circuito_seq_if #(.ERRW(5)) ifc ();

  circuito_seq #(.LAST(30), .ERRW(5)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  circuito_seq #(.LAST(3),  .ERRW(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  circuito_seq #(.LAST(0),  .ERRW(5)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  // Datapath models; the faulty one swaps x0 and x1
  assign ifa.x1 = fault_a ? ~ifa.b0 : ifa.b0;
  assign ifa.x0 = fault_a ? ifa.b0 : ~ifa.b0;
  assign ifb.x1 = fault_b ? ~ifb.b0 : ifb.b0;
  assign ifb.x0 = fault_b ? ifb.b0 : ~ifb.b0;
  assign ifc.x1 = ifc.b0;
  assign ifc.x0 = ~ifc.b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          k;
    int          n;
    logic        b0e;
    logic [4:0]  bb;
    logic        ee;
    logic        dd;

    ifa.start = 1'b0; ifa.cfg_b0 = 1'b0; ifa.cfg_b2 = 1'b0;
    ifb.start = 1'b0; ifb.cfg_b0 = 1'b0; ifb.cfg_b2 = 1'b0;
    ifc.start = 1'b0; ifc.cfg_b0 = 1'b0; ifc.cfg_b2 = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_a", 32'({ifa.b0, ifa.b1, ifa.b2, ifa.e, ifa.busy, ifa.done, ifa.err_cnt}), 32'd0);
    check_eq("rst_b", 32'({ifb.b0, ifb.b1, ifb.b2, ifb.e, ifb.busy, ifb.done, ifb.err_cnt}), 32'd0);

    // Correct sweep, LAST=30, cfg_b0=1; start and cfg_b2 disturbed mid-sweep
    ifa.cfg_b0 = 1'b1; ifa.cfg_b2 = 1'b1; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      ee  = (cyc <= 62);
      dd  = (cyc == 63);
      k   = (cyc <= 62) ? (cyc - 1) / 2 : 30;
      bb  = 5'(k);
      b0e = TOG ? (1'b1 ^ k[0]) : 1'b1;
      check_eq($sformatf("sweep_a_c%0d", cyc),
               32'({ifa.e, ifa.busy, ifa.done, ifa.b0, ifa.b2, ifa.b1}),
               32'({ee, ee, dd, b0e, 1'b1, bb}));
      if (cyc == 10) begin ifa.start = 1'b1; ifa.cfg_b2 = 1'b0; ifa.cfg_b0 = 1'b0; end
      if (cyc == 11) ifa.start = 1'b0;
      if (cyc == 63) check_eq("err_a_ok", 32'(ifa.err_cnt), 32'd0);
      if (cyc < 64) tick();
    end

    // Faulty datapath: every one of 31 steps mismatches
    fault_a = 1'b1; ifa.cfg_b0 = 1'b1; ifa.cfg_b2 = 1'b1; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    n = 0;
    while (!ifa.done && n < 200) begin tick(); n++; end
    check_eq("done_a_fault", 32'(ifa.done), 32'd1);
    check_eq("done_a_fault_cyc", 32'(n + 1), 32'd63);
    check_eq("err_a_fault", 32'(ifa.err_cnt), 32'd31);
    tick();

    // Reset in cycle 10 of a faulty sweep
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check_eq("err_a_c10", 32'(ifa.err_cnt), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_a", 32'({ifa.b0, ifa.b1, ifa.b2, ifa.e, ifa.busy, ifa.done, ifa.err_cnt}), 32'd0);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    fault_a = 1'b0;
    check_eq("restart_a", 32'({ifa.e, ifa.busy, ifa.b0, ifa.b1, ifa.err_cnt}), 32'({1'b1, 1'b1, 1'b1, 5'd0, 5'd0}));
    n = 0;
    while (!ifa.done && n < 200) begin tick(); n++; end
    check_eq("done_a_restart", 32'(ifa.done), 32'd1);
    check_eq("err_a_restart", 32'(ifa.err_cnt), 32'd0);
    tick();

    // LAST=3, cfg_b0=0, correct datapath: b0 per step and done in cycle 9
    ifb.cfg_b0 = 1'b0; ifb.cfg_b2 = 1'b1; ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      ee  = (cyc <= 8);
      dd  = (cyc == 9);
      k   = (cyc <= 8) ? (cyc - 1) / 2 : 3;
      bb  = 5'(k);
      b0e = TOG ? k[0] : 1'b0;
      check_eq($sformatf("sweep_b_c%0d", cyc),
               32'({ifb.e, ifb.busy, ifb.done, ifb.b0, ifb.b2, ifb.b1}),
               32'({ee, ee, dd, b0e, 1'b1, bb}));
      if (cyc < 9) tick();
    end
    check_eq("err_b_ok", 32'(ifb.err_cnt), 32'd0);
    tick();

    // ERRW=2 with four mismatching steps must saturate at 3, not wrap to 0
    fault_b = 1'b1; ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    n = 0;
    while (!ifb.done && n < 50) begin tick(); n++; end
    check_eq("done_b_fault", 32'(ifb.done), 32'd1);
    check_eq("err_b_sat", 32'(ifb.err_cnt), 32'd3);
    tick();

    // LAST=0: a single step
    ifc.cfg_b0 = 1'b1; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    check_eq("c_cyc1", 32'({ifc.e, ifc.busy, ifc.done, ifc.b1}), 32'({1'b1, 1'b1, 1'b0, 5'd0}));
    tick();
    check_eq("c_cyc2", 32'({ifc.e, ifc.busy, ifc.done, ifc.b1}), 32'({1'b1, 1'b1, 1'b0, 5'd0}));
    tick();
    check_eq("c_cyc3", 32'({ifc.e, ifc.busy, ifc.done, ifc.b1}), 32'({1'b0, 1'b0, 1'b1, 5'd0}));
    check_eq("err_c", 32'(ifc.err_cnt), 32'd0);
    tick();
    check_eq("c_cyc4", 32'({ifc.e, ifc.busy, ifc.done}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
